// File: rtl/issue_rsv.sv
// Age-ordered reservation station: holds dispatched ops, captures late operands from two
// writeback buses and issues the oldest fully-ready op over a valid/ready handshake.
module issue_rsv #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 8,
  localparam int unsigned CntW   = $clog2(ENTRIES + 1),
  localparam int unsigned IdxW   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OP_W-1:0]   s_op,
  input  logic [ROB_W-1:0]  s_dst_rob,
  input  logic [ROB_W-1:0]  s_rob0,
  input  logic              s_rdy0,
  input  logic [DATA_W-1:0] s_val0,
  input  logic [ROB_W-1:0]  s_rob1,
  input  logic              s_rdy1,
  input  logic [DATA_W-1:0] s_val1,
  input  logic              wea,
  input  logic [ROB_W-1:0]  dina_rob,
  input  logic [DATA_W-1:0] dina_value,
  input  logic              web,
  input  logic [ROB_W-1:0]  dinb_rob,
  input  logic [DATA_W-1:0] dinb_value,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OP_W-1:0]   m_op,
  output logic [ROB_W-1:0]  m_dst_rob,
  output logic [DATA_W-1:0] m_val0,
  output logic [DATA_W-1:0] m_val1,
  output logic [CntW-1:0]   count
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  dst;
    logic [ROB_W-1:0]  rob0;
    logic              rdy0;
    logic [DATA_W-1:0] val0;
    logic [ROB_W-1:0]  rob1;
    logic              rdy1;
    logic [DATA_W-1:0] val1;
  } entry_t;

  entry_t            ent_q   [ENTRIES];
  entry_t            ent_d   [ENTRIES];
  entry_t            ent_ext [ENTRIES+1];
  entry_t            incoming;
  logic [CntW-1:0]   count_q, count_d, wr_idx;
  logic [ENTRIES-1:0] ready_vec;
  logic [IdxW-1:0]   sel_idx;
  logic              issue, dispatch;

  // Bus A has priority; sources already ready are left untouched.
  function automatic entry_t wake_up(input entry_t e,
                                     input logic wa, input logic [ROB_W-1:0] ta,
                                     input logic [DATA_W-1:0] va,
                                     input logic wb, input logic [ROB_W-1:0] tb,
                                     input logic [DATA_W-1:0] vb);
    entry_t r;
    r = e;
    if (!e.rdy0) begin
      if (wa && ta == e.rob0) begin
        r.rdy0 = 1'b1;
        r.val0 = va;
      end else if (wb && tb == e.rob0) begin
        r.rdy0 = 1'b1;
        r.val0 = vb;
      end
    end
    if (!e.rdy1) begin
      if (wa && ta == e.rob1) begin
        r.rdy1 = 1'b1;
        r.val1 = va;
      end else if (wb && tb == e.rob1) begin
        r.rdy1 = 1'b1;
        r.val1 = vb;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready_vec[i] = ent_q[i].valid & ent_q[i].rdy0 & ent_q[i].rdy1;
    end
  end

  // Lowest ready index is the oldest candidate.
  always_comb begin
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel_idx = IdxW'(i);
    end
  end

  assign m_valid   = |ready_vec;
  assign m_op      = ent_q[sel_idx].op;
  assign m_dst_rob = ent_q[sel_idx].dst;
  assign m_val0    = ent_q[sel_idx].val0;
  assign m_val1    = ent_q[sel_idx].val1;
  assign s_ready   = (count_q != CntW'(ENTRIES));
  assign count     = count_q;

  assign issue    = m_valid & m_ready;
  assign dispatch = s_valid & s_ready;
  assign wr_idx   = count_q - CntW'(issue);

  always_comb begin
    incoming       = '0;
    incoming.valid = 1'b1;
    incoming.op    = s_op;
    incoming.dst   = s_dst_rob;
    incoming.rob0  = s_rob0;
    incoming.rdy0  = s_rdy0;
    incoming.val0  = s_val0;
    incoming.rob1  = s_rob1;
    incoming.rdy1  = s_rdy1;
    incoming.val1  = s_val1;
    incoming = wake_up(incoming, wea, dina_rob, dina_value, web, dinb_rob, dinb_value);
  end

  // Collapse the issued slot, wake the shifted copies, then append the new op at the tail.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) ent_ext[i] = ent_q[i];
    ent_ext[ENTRIES] = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue && (IdxW'(i) >= sel_idx)) begin
        ent_d[i] = ent_ext[i+1];
      end else begin
        ent_d[i] = ent_ext[i];
      end
      ent_d[i] = wake_up(ent_d[i], wea, dina_rob, dina_value, web, dinb_rob, dinb_value);
      if (dispatch && (CntW'(i) == wr_idx)) ent_d[i] = incoming;
    end
    count_d = count_q + CntW'(dispatch) - CntW'(issue);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_rsv.sv
// Scoreboard bench for issue_rsv: directed dispatch/wakeup/flush sequences, with a negedge
// monitor checking every issued op against the expected-issue queue.
module tb_issue_rsv;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        s_valid, s_ready;
  logic [7:0]  s_op;
  logic [3:0]  s_dst_rob, s_rob0, s_rob1;
  logic        s_rdy0, s_rdy1;
  logic [31:0] s_val0, s_val1;
  logic        wea, web;
  logic [3:0]  dina_rob, dinb_rob;
  logic [31:0] dina_value, dinb_value;
  logic        m_valid, m_ready;
  logic [7:0]  m_op;
  logic [3:0]  m_dst_rob;
  logic [31:0] m_val0, m_val1;
  logic [2:0]  count;

  issue_rsv dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_dst_rob(s_dst_rob),
    .s_rob0(s_rob0), .s_rdy0(s_rdy0), .s_val0(s_val0),
    .s_rob1(s_rob1), .s_rdy1(s_rdy1), .s_val1(s_val1),
    .wea(wea), .dina_rob(dina_rob), .dina_value(dina_value),
    .web(web), .dinb_rob(dinb_rob), .dinb_value(dinb_value),
    .m_valid(m_valid), .m_ready(m_ready), .m_op(m_op), .m_dst_rob(m_dst_rob),
    .m_val0(m_val0), .m_val1(m_val1), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  dst;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake that will actually fire must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && !flush && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue_dst", {60'd0, m_dst_rob}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_op", {56'd0, m_op}, {56'd0, e.op});
        check("issue_dst", {60'd0, m_dst_rob}, {60'd0, e.dst});
        check("issue_val0", {32'd0, m_val0}, {32'd0, e.v0});
        check("issue_val1", {32'd0, m_val1}, {32'd0, e.v1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] dst, input logic [3:0] r0, input logic y0,
                        input logic [31:0] v0, input logic [3:0] r1, input logic y1,
                        input logic [31:0] v1);
    s_valid = 1'b1; s_op = {4'h1, dst}; s_dst_rob = dst;
    s_rob0 = r0; s_rdy0 = y0; s_val0 = v0;
    s_rob1 = r1; s_rdy1 = y1; s_val1 = v1;
  endtask

  task automatic push_exp(input logic [3:0] dst, input logic [31:0] v0, input logic [31:0] v1);
    exp_t e;
    e.op = {4'h1, dst}; e.dst = dst; e.v0 = v0; e.v1 = v1;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
    wea = 1'b0; web = 1'b0; dina_rob = '0; dinb_rob = '0; dina_value = '0; dinb_value = '0;
    set_op(4'd2, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2);

    // Reset held two cycles with dispatch pending.
    tick(); tick();
    reset = 1'b0; s_valid = 1'b0;
    check("reset_count", {61'd0, count}, 64'd0);
    check("reset_s_ready", {63'd0, s_ready}, 64'd1);
    check("reset_m_valid", {63'd0, m_valid}, 64'd0);

    // Fully ready op issues the cycle after dispatch.
    m_ready = 1'b1;
    set_op(4'd3, 4'd0, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22);
    push_exp(4'd3, 32'h11, 32'h22);
    tick(); s_valid = 1'b0;
    check("ready_m_valid", {63'd0, m_valid}, 64'd1);
    check("ready_count", {61'd0, count}, 64'd1);
    tick();
    check("ready_count_after", {61'd0, count}, 64'd0);

    // Late operand via bus A.
    set_op(4'd5, 4'd7, 1'b0, 32'h0, 4'd0, 1'b1, 32'h33);
    push_exp(4'd5, 32'hCAFE, 32'h33);
    tick(); s_valid = 1'b0;
    check("wake_wait1", {63'd0, m_valid}, 64'd0);
    tick();
    check("wake_wait2", {63'd0, m_valid}, 64'd0);
    wea = 1'b1; dina_rob = 4'd7; dina_value = 32'hCAFE;
    tick(); wea = 1'b0;
    check("wake_m_valid", {63'd0, m_valid}, 64'd1);
    tick();
    check("wake_count_after", {61'd0, count}, 64'd0);

    // Same-cycle capture from bus B, then both buses matching with A winning.
    set_op(4'd6, 4'd0, 1'b1, 32'h44, 4'd9, 1'b0, 32'h0);
    web = 1'b1; dinb_rob = 4'd9; dinb_value = 32'hBEEF;
    push_exp(4'd6, 32'h44, 32'hBEEF);
    tick(); s_valid = 1'b0; web = 1'b0;
    check("capb_m_valid", {63'd0, m_valid}, 64'd1);
    tick();
    set_op(4'd7, 4'd0, 1'b1, 32'h55, 4'd9, 1'b0, 32'h0);
    wea = 1'b1; dina_rob = 4'd9; dina_value = 32'hAAAA;
    web = 1'b1; dinb_rob = 4'd9; dinb_value = 32'hBBBB;
    push_exp(4'd7, 32'h55, 32'hAAAA);
    tick(); s_valid = 1'b0; wea = 1'b0; web = 1'b0;
    check("capab_m_valid", {63'd0, m_valid}, 64'd1);
    tick();

    // Fill to full with the consumer stalled.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_op(4'(i), 4'd0, 1'b1, 32'(i * 16), 4'd0, 1'b1, 32'(i * 256));
      push_exp(4'(i), 32'(i * 16), 32'(i * 256));
      tick();
    end
    check("full_count", {61'd0, count}, 64'd4);
    check("full_s_ready", {63'd0, s_ready}, 64'd0);
    set_op(4'd15, 4'd0, 1'b1, 32'hF0, 4'd0, 1'b1, 32'hF1);
    tick();
    check("stall_dst_1", {60'd0, m_dst_rob}, 64'd1);
    tick();
    check("stall_dst_2", {60'd0, m_dst_rob}, 64'd1);
    check("stall_count", {61'd0, count}, 64'd4);
    // Issue while full: dispatch must still be refused.
    m_ready = 1'b1;
    tick(); s_valid = 1'b0;
    check("full_issue_count", {61'd0, count}, 64'd3);
    tick(); tick(); tick();
    check("drain_count", {61'd0, count}, 64'd0);

    // Flush beats a same-cycle dispatch and issue.
    m_ready = 1'b0;
    for (int i = 8; i <= 10; i++) begin
      set_op(4'(i), 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0);
      tick();
    end
    s_valid = 1'b0;
    check("pre_flush_count", {61'd0, count}, 64'd3);
    flush = 1'b1; m_ready = 1'b1;
    set_op(4'd11, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("flush_count", {61'd0, count}, 64'd0);
    check("flush_m_valid", {63'd0, m_valid}, 64'd0);
    check("flush_s_ready", {63'd0, s_ready}, 64'd1);
    tick(); tick();

    check("scoreboard_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
